// File: rtl/vm2002_change_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : vm2002_change_dispenser
// Purpose  : Greedy coin payout engine (quarter/dime/nickel) with a
//            valid/ack hopper handshake and saturating coin inventories.
//            Optional hopper-ack timeout: define VM_CHANGE_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module vm2002_change_dispenser #(
    parameter int CNT_W       = 6,
    parameter int INIT_CNT    = 10,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             hrst,
    input  logic             srst,
    input  logic             bal_valid,
    output logic             bal_ready,
    input  logic [15:0]      balance,
    output logic             coin_valid,
    output logic [1:0]       coin,
    input  logic             coin_ack,
    input  logic             restock,
    input  logic [1:0]       restock_coin,
    input  logic [CNT_W-1:0] restock_count,
    output logic [CNT_W-1:0] nickel_cnt,
    output logic [CNT_W-1:0] dime_cnt,
    output logic [CNT_W-1:0] quarter_cnt,
    output logic [15:0]      remaining,
    output logic             done,
    output logic             short_change,
    output logic             timeout_err
);

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_SELECT = 2'd1;
    localparam logic [1:0] c_S_ISSUE  = 2'd2;
    localparam logic [1:0] c_S_FINISH = 2'd3;

    localparam logic [1:0] c_COIN_NONE    = 2'b00;
    localparam logic [1:0] c_COIN_NICKEL  = 2'b01;
    localparam logic [1:0] c_COIN_DIME    = 2'b10;
    localparam logic [1:0] c_COIN_QUARTER = 2'b11;

    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_INIT = CNT_W'(INIT_CNT);

    logic [1:0]       r_state;
    logic             r_bal_ready;
    logic             r_coin_valid;
    logic [1:0]       r_coin;
    logic [15:0]      r_remaining;
    logic             r_done;
    logic             r_short;
    logic [CNT_W-1:0] r_nickel_cnt;
    logic [CNT_W-1:0] r_dime_cnt;
    logic [CNT_W-1:0] r_quarter_cnt;

    logic w_ack_take;
    logic w_dec_n, w_dec_d, w_dec_q;
    logic w_add_n, w_add_d, w_add_q;

    function automatic logic [15:0] f_coin_value(input logic [1:0] code);
        case (code)
            c_COIN_NICKEL:  return 16'd5;
            c_COIN_DIME:    return 16'd10;
            c_COIN_QUARTER: return 16'd25;
            default:        return 16'd0;
        endcase
    endfunction

    // The extra headroom bit keeps count - 1 + add from wrapping before saturation.
    function automatic logic [CNT_W-1:0] f_next_cnt(input logic [CNT_W-1:0] cnt,
                                                    input logic             dec,
                                                    input logic             add_en,
                                                    input logic [CNT_W-1:0] add);
        logic [CNT_W:0] sum;
        sum = {1'b0, cnt} + (add_en ? {1'b0, add} : {(CNT_W+1){1'b0}})
              - {{CNT_W{1'b0}}, dec};
        if (sum > {1'b0, c_CNT_MAX})
            return c_CNT_MAX;
        return sum[CNT_W-1:0];
    endfunction

    // An abort in the same cycle as an ack leaves the inventory untouched.
    assign w_ack_take = (r_state == c_S_ISSUE) && coin_ack && !srst;
    assign w_dec_n    = w_ack_take && (r_coin == c_COIN_NICKEL);
    assign w_dec_d    = w_ack_take && (r_coin == c_COIN_DIME);
    assign w_dec_q    = w_ack_take && (r_coin == c_COIN_QUARTER);
    assign w_add_n    = restock && (restock_coin == c_COIN_NICKEL);
    assign w_add_d    = restock && (restock_coin == c_COIN_DIME);
    assign w_add_q    = restock && (restock_coin == c_COIN_QUARTER);

`ifdef VM_CHANGE_TIMEOUT_EN
    localparam int c_TMO_W = ($clog2(ACK_TIMEOUT + 1) > 8) ? $clog2(ACK_TIMEOUT + 1) : 8;
    logic [c_TMO_W-1:0] r_tmo;
    logic               r_timeout_err;
    assign timeout_err = r_timeout_err;
`else
    logic [31:0] w_unused_tmo;
    assign w_unused_tmo = ACK_TIMEOUT;
    assign timeout_err  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (hrst) begin
            r_state       <= c_S_IDLE;
            r_bal_ready   <= 1'b1;
            r_coin_valid  <= 1'b0;
            r_coin        <= c_COIN_NONE;
            r_remaining   <= 16'd0;
            r_done        <= 1'b0;
            r_short       <= 1'b0;
            r_nickel_cnt  <= c_CNT_INIT;
            r_dime_cnt    <= c_CNT_INIT;
            r_quarter_cnt <= c_CNT_INIT;
`ifdef VM_CHANGE_TIMEOUT_EN
            r_tmo         <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            r_done        <= 1'b0;
            r_short       <= 1'b0;
            r_nickel_cnt  <= f_next_cnt(r_nickel_cnt,  w_dec_n, w_add_n, restock_count);
            r_dime_cnt    <= f_next_cnt(r_dime_cnt,    w_dec_d, w_add_d, restock_count);
            r_quarter_cnt <= f_next_cnt(r_quarter_cnt, w_dec_q, w_add_q, restock_count);
`ifdef VM_CHANGE_TIMEOUT_EN
            r_timeout_err <= 1'b0;
`endif
            if (srst && (r_state != c_S_IDLE)) begin
                r_state      <= c_S_IDLE;
                r_bal_ready  <= 1'b1;
                r_coin_valid <= 1'b0;
                r_coin       <= c_COIN_NONE;
            end else begin
                case (r_state)
                    c_S_IDLE: begin
                        if (bal_valid && r_bal_ready) begin
                            r_remaining <= balance;
                            r_bal_ready <= 1'b0;
                            r_state     <= c_S_SELECT;
                        end
                    end
                    c_S_SELECT: begin
                        if (r_remaining == 16'd0) begin
                            r_done  <= 1'b1;
                            r_state <= c_S_FINISH;
                        end else if (r_remaining >= 16'd25 && r_quarter_cnt != '0) begin
                            r_coin       <= c_COIN_QUARTER;
                            r_coin_valid <= 1'b1;
                            r_state      <= c_S_ISSUE;
                        end else if (r_remaining >= 16'd10 && r_dime_cnt != '0) begin
                            r_coin       <= c_COIN_DIME;
                            r_coin_valid <= 1'b1;
                            r_state      <= c_S_ISSUE;
                        end else if (r_remaining >= 16'd5 && r_nickel_cnt != '0) begin
                            r_coin       <= c_COIN_NICKEL;
                            r_coin_valid <= 1'b1;
                            r_state      <= c_S_ISSUE;
                        end else begin
                            r_short <= 1'b1;
                            r_state <= c_S_FINISH;
                        end
`ifdef VM_CHANGE_TIMEOUT_EN
                        r_tmo <= c_TMO_W'(ACK_TIMEOUT);
`endif
                    end
                    c_S_ISSUE: begin
                        if (coin_ack) begin
                            r_remaining  <= r_remaining - f_coin_value(r_coin);
                            r_coin       <= c_COIN_NONE;
                            r_coin_valid <= 1'b0;
                            r_state      <= c_S_SELECT;
                        end
`ifdef VM_CHANGE_TIMEOUT_EN
                        else if (r_tmo < c_TMO_W'(2)) begin
                            r_coin        <= c_COIN_NONE;
                            r_coin_valid  <= 1'b0;
                            r_timeout_err <= 1'b1;
                            r_bal_ready   <= 1'b1;
                            r_state       <= c_S_IDLE;
                        end else begin
                            r_tmo <= r_tmo - 1'b1;
                        end
`endif
                    end
                    default: begin
                        r_bal_ready <= 1'b1;
                        r_state     <= c_S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bal_ready    = r_bal_ready;
    assign coin_valid   = r_coin_valid;
    assign coin         = r_coin;
    assign remaining    = r_remaining;
    assign done         = r_done;
    assign short_change = r_short;
    assign nickel_cnt   = r_nickel_cnt;
    assign dime_cnt     = r_dime_cnt;
    assign quarter_cnt  = r_quarter_cnt;

endmodule
`default_nettype wire

// File: tb/tb_vm2002_change_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : tb_vm2002_change_dispenser
// Purpose  : Randomized and directed bench for vm2002_change_dispenser with a
//            greedy-payout reference model. Timeout checks need VM_CHANGE_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vm2002_change_dispenser;

    localparam int CNT_W   = 6;
    localparam int CNT_MAX = 63;
`ifdef VM_CHANGE_TIMEOUT_EN
    localparam int HOLD = 2;
`else
    localparam int HOLD = 5;
`endif

    logic             clk = 1'b0;
    logic             hrst = 1'b0, srst = 1'b0;
    logic             bal_valid = 1'b0;
    logic             bal_ready;
    logic [15:0]      balance = '0;
    logic             coin_valid;
    logic [1:0]       coin;
    logic             coin_ack = 1'b0;
    logic             restock = 1'b0;
    logic [1:0]       restock_coin = '0;
    logic [CNT_W-1:0] restock_count = '0;
    logic [CNT_W-1:0] nickel_cnt, dime_cnt, quarter_cnt;
    logic [15:0]      remaining;
    logic             done, short_change, timeout_err;

    int checks = 0;
    int failures = 0;
    int m_cnt[4];

    vm2002_change_dispenser #(.CNT_W(CNT_W), .INIT_CNT(10), .ACK_TIMEOUT(4)) dut (
        .clk(clk), .hrst(hrst), .srst(srst),
        .bal_valid(bal_valid), .bal_ready(bal_ready), .balance(balance),
        .coin_valid(coin_valid), .coin(coin), .coin_ack(coin_ack),
        .restock(restock), .restock_coin(restock_coin), .restock_count(restock_count),
        .nickel_cnt(nickel_cnt), .dime_cnt(dime_cnt), .quarter_cnt(quarter_cnt),
        .remaining(remaining), .done(done), .short_change(short_change),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int coin_value(input int c);
        return (c == 3) ? 25 : (c == 2) ? 10 : (c == 1) ? 5 : 0;
    endfunction

    function automatic logic [CNT_W-1:0] dut_cnt(input int c);
        return (c == 3) ? quarter_cnt : (c == 2) ? dime_cnt : nickel_cnt;
    endfunction

    task automatic do_hrst();
        hrst = 1'b1;
        step();
        step();
        hrst = 1'b0;
        for (int i = 1; i < 4; i++) m_cnt[i] = 10;
    endtask

    task automatic idle_restock(input int c, input int n);
        restock = 1'b1;
        restock_coin = 2'(c);
        restock_count = CNT_W'(n);
        step();
        restock = 1'b0;
        if (c != 0) m_cnt[c] = (m_cnt[c] + n > CNT_MAX) ? CNT_MAX : m_cnt[c] + n;
        check("restock_n", nickel_cnt, m_cnt[1]);
        check("restock_d", dime_cnt, m_cnt[2]);
        check("restock_q", quarter_cnt, m_cnt[3]);
    endtask

    // Whole-payout reference: greedy coin list derived from the current model inventory.
    task automatic payout(input int bal, input int max_delay);
        int exp_q[$];
        int tmp[4];
        int rem, c, waited, d;
        rem = bal;
        tmp = m_cnt;
        while (rem > 0) begin
            if (rem >= 25 && tmp[3] > 0) c = 3;
            else if (rem >= 10 && tmp[2] > 0) c = 2;
            else if (rem >= 5 && tmp[1] > 0) c = 1;
            else break;
            exp_q.push_back(c);
            rem -= coin_value(c);
            tmp[c]--;
        end
        bal_valid = 1'b1;
        balance = 16'(bal);
        step();
        bal_valid = 1'b0;
        check("accept_remaining", remaining, bal);
        check("busy_ready", bal_ready, 0);
        rem = bal;
        foreach (exp_q[i]) begin
            waited = 0;
            while (!coin_valid && waited < 8) begin
                step();
                waited++;
            end
            check("coin_gap", waited, 1);
            if (!coin_valid) return;
            check("coin_code", coin, exp_q[i]);
            d = $urandom_range(0, max_delay);
            repeat (d) begin
                step();
                check("hold_valid", coin_valid, 1);
                check("hold_coin", coin, exp_q[i]);
            end
            coin_ack = 1'b1;
            step();
            coin_ack = 1'b0;
            rem -= coin_value(exp_q[i]);
            m_cnt[exp_q[i]]--;
            check("ack_remaining", remaining, rem);
            check("ack_valid", coin_valid, 0);
            check("ack_cnt", dut_cnt(exp_q[i]), m_cnt[exp_q[i]]);
        end
        step();
        check("end_done", done, (rem == 0) ? 1 : 0);
        check("end_short", short_change, (rem != 0) ? 1 : 0);
        check("end_remaining", remaining, rem);
        step();
        check("post_done", done, 0);
        check("post_short", short_change, 0);
        check("post_ready", bal_ready, 1);
        check("post_remaining", remaining, rem);
    endtask

    initial begin
        do_hrst();
        check("rst_ready", bal_ready, 1);
        check("rst_valid", coin_valid, 0);
        check("rst_coin", coin, 0);
        check("rst_remaining", remaining, 0);
        check("rst_done", done, 0);
        check("rst_short", short_change, 0);
        check("rst_tmo", timeout_err, 0);
        check("rst_n", nickel_cnt, 10);
        check("rst_d", dime_cnt, 10);
        check("rst_q", quarter_cnt, 10);

        payout(65, 0);
        check("p65_q", quarter_cnt, 8);
        check("p65_d", dime_cnt, 9);
        check("p65_n", nickel_cnt, 9);

        do_hrst();
        payout(250, 2);
        check("drain_q", quarter_cnt, 0);
        payout(30, 1);
        check("p30_d", dime_cnt, 7);
        payout(7, 0);
        check("p7_remaining", remaining, 2);

        // Abort a stalled quarter with a soft reset.
        do_hrst();
        bal_valid = 1'b1;
        balance = 16'd25;
        step();
        bal_valid = 1'b0;
        step();
        check("srst_coin", coin, 3);
        repeat (HOLD) begin
            step();
            check("stall_valid", coin_valid, 1);
            check("stall_coin", coin, 3);
            check("stall_tmo", timeout_err, 0);
        end
        srst = 1'b1;
        step();
        srst = 1'b0;
        check("srst_valid", coin_valid, 0);
        check("srst_q", quarter_cnt, 10);
        check("srst_remaining", remaining, 25);
        check("srst_ready", bal_ready, 1);
        check("srst_done", done, 0);
        check("srst_short", short_change, 0);
        step();
        check("srst_done2", done, 0);
        check("srst_short2", short_change, 0);

        // Restock colliding with a quarter ack, then saturation.
        do_hrst();
        bal_valid = 1'b1;
        balance = 16'd25;
        step();
        bal_valid = 1'b0;
        step();
        check("rq_coin", coin, 3);
        coin_ack = 1'b1;
        restock = 1'b1;
        restock_coin = 2'b11;
        restock_count = 6'd3;
        step();
        coin_ack = 1'b0;
        restock = 1'b0;
        m_cnt[3] = 12;
        check("rq_q", quarter_cnt, 12);
        step();
        check("rq_done", done, 1);
        step();
        idle_restock(3, 60);
        check("sat_q", quarter_cnt, 63);
        idle_restock(3, 1);
        idle_restock(0, 40);

`ifdef VM_CHANGE_TIMEOUT_EN
        begin
            int n;
            do_hrst();
            bal_valid = 1'b1;
            balance = 16'd25;
            step();
            bal_valid = 1'b0;
            step();
            n = 0;
            while (coin_valid && n < 20) begin
                n++;
                step();
            end
            check("tmo_cycles", n, 4);
            check("tmo_pulse", timeout_err, 1);
            check("tmo_ready", bal_ready, 1);
            check("tmo_q", quarter_cnt, 10);
            check("tmo_remaining", remaining, 25);
            step();
            check("tmo_pulse_end", timeout_err, 0);
        end
`endif

        do_hrst();
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 2) == 0)
                idle_restock($urandom_range(0, 3), $urandom_range(0, 63));
            payout($urandom_range(0, 200), 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vm2002_change_dispenser.md
Name: vm2002_change_dispenser

Overview:
Payout engine on the customer-facing side of the vm2002 coin path. It accepts a change amount in cents from the vending FSM's balance output. It issues coins one at a time to the coin hopper over a valid/ack handshake, using a greedy choice of quarter, then dime, then nickel. It keeps per-denomination coin inventory counters, which the supplier restocks.

Parameters:
CNT_W, 6, width of each coin inventory counter; counters saturate at 2^CNT_W-1
INIT_CNT, 10, inventory value of every denomination after hrst
ACK_TIMEOUT, 255, maximum cycles to wait for coin_ack (used only when the optional feature is compiled in)

Ports:
clk  in  1  system clock; all logic on posedge clk
hrst  in  1  synchronous active-high hard reset
srst  in  1  synchronous active-high soft reset; aborts the payout, keeps remaining and inventory
bal_valid  in  1  change request valid
bal_ready  out  1  high only in IDLE; a request is accepted when bal_valid && bal_ready
balance  in  16  change owed, in cents
coin_valid  out  1  coin offered to the hopper
coin  out  2  coin code: 00 none, 01 NICKEL (5), 10 DIME (10), 11 QUARTER (25)
coin_ack  in  1  hopper has taken the offered coin
restock  in  1  add restock_count to the restock_coin inventory this cycle
restock_coin  in  2  coin code to restock; 00 is ignored
restock_count  in  CNT_W  number of coins to add
nickel_cnt, dime_cnt, quarter_cnt  out  CNT_W each  current inventory
remaining  out  16  cents still owed
done  out  1  one-cycle pulse: payout complete, remaining==0
short_change  out  1  one-cycle pulse: payout stopped with remaining>0 (inventory or granularity)
timeout_err  out  1  one-cycle pulse on hopper ack timeout (tied 0 without the optional feature)

Behaviour:
- Reset (hrst): state IDLE; bal_ready=1; coin_valid=0; coin=00; remaining=0; done, short_change and timeout_err = 0; all counters = INIT_CNT. hrst has priority over srst.
- States: IDLE, SELECT, ISSUE, FINISH.
- IDLE:
  - bal_ready=1.
  - On accept at edge T, remaining<=balance and the FSM goes to SELECT.
- SELECT (bal_ready=0, coin_valid=0), first matching rule wins:
  - remaining==0 -> FINISH, then done pulses.
  - remaining>=25 and quarter_cnt>0 -> coin<=11, go to ISSUE.
  - else remaining>=10 and dime_cnt>0 -> coin<=10, go to ISSUE.
  - else remaining>=5 and nickel_cnt>0 -> coin<=01, go to ISSUE.
  - else -> FINISH, then short_change pulses.
- Latency: the first coin_valid is high in the cycle after T+1, i.e. two edges after accept.
- ISSUE:
  - coin_valid=1; coin is held stable until coin_ack is sampled high.
  - On the ack edge: remaining -= coin value, the matching counter decrements by 1, coin<=00, coin_valid<=0, go to SELECT.
  - A new coin is therefore offered at most every 2 cycles.
- FINISH:
  - Exactly one of done or short_change is high for one cycle, then IDLE.
  - remaining keeps its final value until the next accept.
- coin_ack outside ISSUE is ignored.
- Restock is accepted in any state:
  - new count = count + restock_count, saturating at 2^CNT_W-1.
  - If an ack decrement and a restock of the same denomination occur in the same cycle, new count = count - 1 + restock_count, saturating.
  - A restock that lands during SELECT is visible to the next SELECT evaluation, not the current one.
- srst in any non-IDLE state: next state IDLE; coin_valid=0 on the next cycle; no counter change; remaining is preserved so the value still owed stays observable; no done or short_change pulse.
- All arithmetic is unsigned 16-bit. Counters never go below 0, because SELECT only offers a coin when its counter is nonzero.

Optional Feature:
VM_CHANGE_TIMEOUT_EN
- Defined:
  - An 8-bit-or-wider down-counter loads ACK_TIMEOUT on entry to ISSUE and decrements each ISSUE cycle without an ack.
  - When it reaches 0 with no ack: coin_valid drops, no inventory change, timeout_err pulses 1 cycle, FSM returns to IDLE, remaining is preserved.
  - An ack in the same cycle that the count reaches 0 wins, and the coin is counted.
- Not defined: ISSUE waits indefinitely; timeout_err is constant 0.

Test Plan:
- hrst, then balance=65 with immediate acks -> coins 11,11,10,01 (one per 2 cycles); remaining 65->40->15->5->0; done pulse; quarter_cnt=8, dime_cnt=9, nickel_cnt=9.
- quarter_cnt restocked to 0 via hrst+drain, balance=30 -> coins 10,10,10; done pulse; remaining=0.
- balance=7 -> one nickel, then short_change pulse with remaining=2; bal_ready back to 1 the cycle after.
- In ISSUE with coin=11, hold coin_ack low 5 cycles -> coin/coin_valid stable; then assert srst -> coin_valid=0 next cycle, quarter_cnt unchanged, remaining=original balance.
- During a quarter ack, restock QUARTER count 3 with quarter_cnt=10 -> quarter_cnt=12; restock to saturation with CNT_W=6 -> holds at 63.
- With VM_CHANGE_TIMEOUT_EN and ACK_TIMEOUT=4, no ack -> coin_valid drops after 4 ISSUE cycles, timeout_err pulses once, FSM in IDLE, counters unchanged.
